// File: rtl/seg7_scan_ctrl.sv
// Six-digit seven-segment scan controller sharing one BCD decoder across all digits.
// Optional leading-zero suppression is enabled by defining SEG7_LZS_EN.

module seg7dec (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    // gfedcba, active low; non-BCD codes stay dark
    always_comb begin
        seg = 7'b1111111;
        case (nib)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

module seg7_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [23:0] DIN,
    input  logic [5:0]  BLANK,
    input  logic [5:0]  BLINK,
    output logic [6:0]  nHEX0,
    output logic [6:0]  nHEX1,
    output logic [6:0]  nHEX2,
    output logic [6:0]  nHEX3,
    output logic [6:0]  nHEX4,
    output logic [6:0]  nHEX5,
    output logic        FRAME
);
    localparam int CW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [2:0]        idx_reg, idx_next;
    logic [23:0]       data_reg, data_next;
    logic [5:0]        blank_reg, blank_next;
    logic [5:0]        blink_reg, blink_next;
    logic [BW-1:0]     bcnt_reg, bcnt_next;
    logic              phase_reg, phase_next;
    logic              frame_reg, frame_next;
    logic [5:0][6:0]   hex_reg, hex_next;

    logic              tick;
    logic [23:0]       src_data;
    logic [5:0]        src_blank;
    logic [5:0]        src_blink;
    logic [5:0][3:0]   nib_arr;
    logic [3:0]        nib;
    logic [6:0]        dec_seg;
    logic [6:0]        pat;

    assign tick = (cnt_reg == CNT_MAX);

    // Digit 0 reads the live inputs; the rest of the sweep reads the copy taken then
    assign src_data  = (idx_reg == 3'd0) ? DIN   : data_reg;
    assign src_blank = (idx_reg == 3'd0) ? BLANK : blank_reg;
    assign src_blink = (idx_reg == 3'd0) ? BLINK : blink_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_nib
            assign nib_arr[gi] = src_data[4*gi +: 4];
        end
    endgenerate

    assign nib = nib_arr[idx_reg];

    seg7dec u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

`ifdef SEG7_LZS_EN
    logic [5:0] lz_dark;
    assign lz_dark[0] = 1'b0;
    generate
        for (gi = 1; gi < 6; gi++) begin : g_lz
            assign lz_dark[gi] = ~|src_data[23:4*gi];
        end
    endgenerate
`endif

    always_comb begin
        pat = dec_seg;
        if (src_blank[idx_reg] || (src_blink[idx_reg] && phase_reg))
            pat = 7'b1111111;
`ifdef SEG7_LZS_EN
        if (lz_dark[idx_reg])
            pat = 7'b1111111;
`endif
    end

    always_comb begin
        cnt_next   = tick ? '0 : cnt_reg + CW'(1);
        idx_next   = idx_reg;
        data_next  = data_reg;
        blank_next = blank_reg;
        blink_next = blink_reg;
        frame_next = 1'b0;
        if (tick) begin
            idx_next   = (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
            frame_next = (idx_reg == 3'd5);
            if (idx_reg == 3'd0) begin
                data_next  = DIN;
                blank_next = BLANK;
                blink_next = BLINK;
            end
        end
    end

    // Blink phase runs independently of the scan; a tick on the wrap edge sees the old phase
    always_comb begin
        bcnt_next  = bcnt_reg + BW'(1);
        phase_next = phase_reg;
        if (bcnt_reg == BLINK_MAX) begin
            bcnt_next  = '0;
            phase_next = ~phase_reg;
        end
    end

    generate
        for (gi = 0; gi < 6; gi++) begin : g_hex
            assign hex_next[gi] = (tick && (idx_reg == 3'(gi))) ? pat : hex_reg[gi];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_reg   <= '0;
            idx_reg   <= 3'd0;
            data_reg  <= '0;
            blank_reg <= '0;
            blink_reg <= '0;
            bcnt_reg  <= '0;
            phase_reg <= 1'b0;
            frame_reg <= 1'b0;
            hex_reg   <= {6{7'b1111111}};
        end else begin
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            blank_reg <= blank_next;
            blink_reg <= blink_next;
            bcnt_reg  <= bcnt_next;
            phase_reg <= phase_next;
            frame_reg <= frame_next;
            hex_reg   <= hex_next;
        end
    end

    assign nHEX0 = hex_reg[0];
    assign nHEX1 = hex_reg[1];
    assign nHEX2 = hex_reg[2];
    assign nHEX3 = hex_reg[3];
    assign nHEX4 = hex_reg[4];
    assign nHEX5 = hex_reg[5];
    assign FRAME = frame_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: instance a (SCAN_DIV=4) covers reset, sweep, tearing,
// masks and mid-sweep reset; instance b (SCAN_DIV=1, BLINK_DIV=32) covers blinking.

module tb_seg7_scan_ctrl;
    logic        CLK = 1'b0;
    logic        RST;
    logic [23:0] DIN;
    logic [5:0]  BLANK;
    logic [5:0]  BLINK;

    logic [6:0] a_hex0, a_hex1, a_hex2, a_hex3, a_hex4, a_hex5;
    logic       a_frame;
    logic [6:0] b_hex0, b_hex1, b_hex2, b_hex3, b_hex4, b_hex5;
    logic       b_frame;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, DK = 7'b1111111;

    seg7_scan_ctrl #(.SCAN_DIV(4), .BLINK_DIV(32)) dut_a (
        .CLK(CLK), .RST(RST), .DIN(DIN), .BLANK(BLANK), .BLINK(BLINK),
        .nHEX0(a_hex0), .nHEX1(a_hex1), .nHEX2(a_hex2), .nHEX3(a_hex3),
        .nHEX4(a_hex4), .nHEX5(a_hex5), .FRAME(a_frame)
    );

    seg7_scan_ctrl #(.SCAN_DIV(1), .BLINK_DIV(32)) dut_b (
        .CLK(CLK), .RST(RST), .DIN(DIN), .BLANK(BLANK), .BLINK(BLINK),
        .nHEX0(b_hex0), .nHEX1(b_hex1), .nHEX2(b_hex2), .nHEX3(b_hex3),
        .nHEX4(b_hex4), .nHEX5(b_hex5), .FRAME(b_frame)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Expected pattern packed as {d5,d4,d3,d2,d1,d0}
    task automatic check_a(input string tag, input logic [41:0] exp);
        check({tag, ".hex0"}, 32'(a_hex0), 32'(exp[6:0]));
        check({tag, ".hex1"}, 32'(a_hex1), 32'(exp[13:7]));
        check({tag, ".hex2"}, 32'(a_hex2), 32'(exp[20:14]));
        check({tag, ".hex3"}, 32'(a_hex3), 32'(exp[27:21]));
        check({tag, ".hex4"}, 32'(a_hex4), 32'(exp[34:28]));
        check({tag, ".hex5"}, 32'(a_hex5), 32'(exp[41:35]));
    endtask

    initial begin
        RST   = 1'b1;
        DIN   = 24'h123456;
        BLANK = 6'b0;
        BLINK = 6'b0;

        for (int i = 0; i < 3; i++) begin
            step(1);
            check_a("rst", {6{DK}});
            check("rst.frame_a", 32'(a_frame), 32'd0);
            check("rst.hex0_b", 32'(b_hex0), 32'(DK));
        end
        RST = 1'b0;

        step(3);
        check("first_tick.early", 32'(a_hex0), 32'(DK));
        step(1);
        check("first_tick.hex0", 32'(a_hex0), 32'(S6));
        check("first_tick.hex1", 32'(a_hex1), 32'(DK));
        step(19);
        check("sweep.frame_pre", 32'(a_frame), 32'd0);
        step(1);
        check_a("sweep", {S1, S2, S3, S4, S5, S6});
        check("sweep.frame", 32'(a_frame), 32'd1);

        DIN = 24'h111111;
        step(1);
        check("sweep.frame_post", 32'(a_frame), 32'd0);
        step(3);
        check("tear.hex0", 32'(a_hex0), 32'(S1));
        DIN = 24'h999999;
        step(20);
        check_a("tear.held", {6{S1}});
        step(24);
        check_a("tear.next", {6{S9}});

        DIN = 24'hABCDEF;
        step(24);
        check_a("nonbcd", {6{DK}});
        DIN   = 24'h888888;
        BLANK = 6'b000100;
        step(24);
        check_a("blank2", {S8, S8, S8, DK, S8, S8});
        BLANK = 6'b0;

        DIN = 24'h000705;
        step(24);
`ifdef SEG7_LZS_EN
        check_a("lzs705", {DK, DK, DK, S7, S0, S5});
`else
        check_a("val705", {S0, S0, S0, S7, S0, S5});
`endif
        DIN = 24'h000000;
        step(24);
`ifdef SEG7_LZS_EN
        check_a("lzs0", {DK, DK, DK, DK, DK, S0});
`else
        check_a("val0", {6{S0}});
`endif

        DIN = 24'h123456;
        step(10);
        check("midrst.pre_hex1", 32'(a_hex1), 32'(S5));
        RST = 1'b1;
        step(1);
        check_a("midrst", {6{DK}});
        check("midrst.frame", 32'(a_frame), 32'd0);
        RST = 1'b0;
        step(3);
        check("midrst.early", 32'(a_hex0), 32'(DK));
        step(1);
        check("midrst.hex0", 32'(a_hex0), 32'(S6));
        check("midrst.hex1", 32'(a_hex1), 32'(DK));

        RST   = 1'b1;
        DIN   = 24'h000000;
        BLINK = 6'b000001;
        step(1);
        RST = 1'b0;
        step(28);
        check("blink.on1", 32'(b_hex0), 32'(S0));
`ifdef SEG7_LZS_EN
        check("blink.hex1", 32'(b_hex1), 32'(DK));
`else
        check("blink.hex1", 32'(b_hex1), 32'(S0));
`endif
        step(32);
        check("blink.off1", 32'(b_hex0), 32'(DK));
`ifdef SEG7_LZS_EN
        check("blink.hex5", 32'(b_hex5), 32'(DK));
`else
        check("blink.hex5", 32'(b_hex5), 32'(S0));
`endif
        step(32);
        check("blink.on2", 32'(b_hex0), 32'(S0));
        step(32);
        check("blink.off2", 32'(b_hex0), 32'(DK));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
